// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: binary -> 4-digit BCD via an iterative shift-add-3
// engine, plus a free-running time-multiplexed scan of the four 7-segment
// digits. seg is active-low, ordered {a,b,c,d,e,f,g} from MSB to LSB.
module display_scan_ctrl #(
  parameter int N_in     = 10,
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [N_in-1:0] bin_in,
  output logic            busy,
  output logic            done,
  output logic            ovf,
  output logic [15:0]     digits,
  output logic [3:0]      an,
  output logic [6:0]      seg
);

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_CONV = 2'd1;
  localparam logic [1:0]  ST_DONE = 2'd2;
  localparam logic [31:0] CLAMP   = 32'd9999;
  localparam int          PRE_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N_in-1:0] op_q, op_d;
  logic [15:0]     bcd_q, bcd_d, bcd_adj;
  logic            ovfp_q, ovfp_d;
  logic [15:0]     digits_q, digits_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             wrap;
  logic [3:0]       nib;
  logic [3:0]       lz;

  function automatic logic [15:0] add3(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b0000001;
      4'd1:    glyph = 7'b1001111;
      4'd2:    glyph = 7'b0010010;
      4'd3:    glyph = 7'b0000110;
      4'd4:    glyph = 7'b1001100;
      4'd5:    glyph = 7'b0100100;
      4'd6:    glyph = 7'b0100000;
      4'd7:    glyph = 7'b0001111;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0000100;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  assign bcd_adj = add3(bcd_q);

  // Conversion FSM next-state: capture/clamp, shift-add-3 per bit, publish.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    bcd_d    = bcd_q;
    ovfp_d   = ovfp_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bcd_d   = '0;
          cnt_d   = 4'(N_in - 1);
          state_d = ST_CONV;
          if (32'(bin_in) > CLAMP) begin
            op_d   = CLAMP[N_in-1:0];
            ovfp_d = 1'b1;
          end else begin
            op_d   = bin_in;
            ovfp_d = 1'b0;
          end
        end
      end
      ST_CONV: begin
        bcd_d = (bcd_adj << 1) | {15'b0, op_q[N_in-1]};
        op_d  = op_q << 1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = ST_DONE;
      end
      ST_DONE: begin
        digits_d = bcd_q;
        ovf_d    = ovfp_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and published-result registers; reset aborts any conversion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ovfp_q   <= 1'b0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ovfp_q   <= ovfp_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Datapath shift registers; always loaded in IDLE before use, so no reset.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    bcd_q <= bcd_d;
  end

  // Scan next-state: prescaler, digit index, leading-zero blanking, decode.
  always_comb begin
    wrap    = (presc_q == PRE_W'(SCAN_DIV - 1));
    presc_d = wrap ? '0 : presc_q + 1'b1;
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    lz[3]   = (digits_q[15:12] == 4'd0);
    lz[2]   = lz[3] && (digits_q[11:8] == 4'd0);
    lz[1]   = lz[2] && (digits_q[7:4] == 4'd0);
    lz[0]   = 1'b0;
    case (idx_d)
      2'd0:    nib = digits_q[3:0];
      2'd1:    nib = digits_q[7:4];
      2'd2:    nib = digits_q[11:8];
      default: nib = digits_q[15:12];
    endcase
    an_d  = ~(4'b0001 << idx_d);
    seg_d = (BLANK_LZ && lz[idx_d]) ? 7'b1111111 : glyph(nib);
  end

  // Scan registers: an and seg update together so they are never skewed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b0000001;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign busy   = (state_q == ST_CONV);
  assign done   = done_q;
  assign ovf    = ovf_q;
  assign digits = digits_q;
  assign an     = an_q;
  assign seg    = seg_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two instances (10-bit unblanked, 14-bit
// blanked), scoreboard queues of expected results, per-cycle monitors.
module tb_display_scan_ctrl;

  localparam int NA = 10;
  localparam int NB = 14;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst;
  logic load_a, load_b;
  logic [NA-1:0] bin_a;
  logic [NB-1:0] bin_b;
  logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [15:0] digits_a, digits_b;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;

  display_scan_ctrl #(.N_in(NA), .SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_a (
    .clk(clk), .rst(rst), .load(load_a), .bin_in(bin_a), .busy(busy_a),
    .done(done_a), .ovf(ovf_a), .digits(digits_a), .an(an_a), .seg(seg_a));

  display_scan_ctrl #(.N_in(NB), .SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst(rst), .load(load_b), .bin_in(bin_b), .busy(busy_b),
    .done(done_b), .ovf(ovf_b), .digits(digits_b), .an(an_b), .seg(seg_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    bit ovf;
    int cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   next_ok[2];
  int   acc[2];
  int   disp_val[2];
  bit   disp_ovf[2];
  logic [3:0] prev_an[2];
  int   last_chg[2];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, expv);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] std_glyph(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  // Expected segments for the position selected by an, from the decimal value.
  function automatic logic [6:0] exp_seg(input int w, input logic [3:0] a);
    int pos;
    int p10;
    case (a)
      4'b1110: pos = 0;
      4'b1101: pos = 1;
      4'b1011: pos = 2;
      default: pos = 3;
    endcase
    p10 = (pos == 0) ? 1 : (pos == 1) ? 10 : (pos == 2) ? 100 : 1000;
    if (w == 1 && pos > 0 && disp_val[w] < p10) return 7'b1111111;
    return std_glyph((disp_val[w] / p10) % 10);
  endfunction

  task automatic mon(input int w, input logic dn, input logic bz, input logic [15:0] dg,
                     input logic ov, input logic [3:0] a, input logic [6:0] sg);
    int n;
    bit eb;
    exp_t e;
    n  = (w == 0) ? NA : NB;
    eb = (cyc >= acc[w]) && (cyc <= acc[w] + n - 1);
    chk($sformatf("busy%0d", w), 32'(bz), 32'(eb));
    if (a != prev_an[w]) begin
      chk($sformatf("an_rot%0d", w), 32'(a), 32'({prev_an[w][2:0], prev_an[w][3]}));
      if (last_chg[w] >= 0) chk($sformatf("an_period%0d", w), 32'(cyc - last_chg[w]), 32'(SD));
      chk($sformatf("seg%0d", w), 32'(sg), 32'(exp_seg(w, a)));
      prev_an[w]  = a;
      last_chg[w] = cyc;
    end
    if (dn) begin
      if ((w == 0 && qa.size() == 0) || (w == 1 && qb.size() == 0)) begin
        chk($sformatf("done_spurious%0d", w), 32'(dn), 32'd0);
      end else begin
        e = (w == 0) ? qa.pop_front() : qb.pop_front();
        chk($sformatf("digits%0d", w), 32'(dg), 32'(to_bcd(e.val)));
        chk($sformatf("ovf%0d", w), 32'(ov), 32'(e.ovf));
        chk($sformatf("done_cycle%0d", w), 32'(cyc), 32'(e.cyc));
        disp_val[w] = e.val;
        disp_ovf[w] = e.ovf;
      end
    end else begin
      chk($sformatf("digits_hold%0d", w), 32'(dg), 32'(to_bcd(disp_val[w])));
      chk($sformatf("ovf_hold%0d", w), 32'(ov), 32'(disp_ovf[w]));
    end
  endtask

  always @(negedge clk) if (rst) mon(0, done_a, busy_a, digits_a, ovf_a, an_a, seg_a);
  always @(negedge clk) if (rst) mon(1, done_b, busy_b, digits_b, ovf_b, an_b, seg_b);

  task automatic do_load(input int w, input int v);
    int k;
    int n;
    exp_t e;
    @(negedge clk);
    k = cyc + 1;
    n = (w == 0) ? NA : NB;
    if (w == 0) begin bin_a = v[NA-1:0]; load_a = 1'b1; end
    else        begin bin_b = v[NB-1:0]; load_b = 1'b1; end
    if (k >= next_ok[w]) begin
      e.val = (v > 9999) ? 9999 : v;
      e.ovf = (v > 9999);
      e.cyc = k + n + 1;
      if (w == 0) qa.push_back(e); else qb.push_back(e);
      acc[w]     = k;
      next_ok[w] = k + n + 2;
    end
    @(posedge clk);
    #1;
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    for (int w = 0; w < 2; w++) begin
      next_ok[w] = 0; acc[w] = -100; disp_val[w] = 0; disp_ovf[w] = 0;
      prev_an[w] = 4'b1110; last_chg[w] = -1;
    end
    chk("rst_an_a", 32'(an_a), 32'h0e);      chk("rst_an_b", 32'(an_b), 32'h0e);
    chk("rst_seg_a", 32'(seg_a), 32'h01);    chk("rst_seg_b", 32'(seg_b), 32'h01);
    chk("rst_digits_a", 32'(digits_a), 0);   chk("rst_digits_b", 32'(digits_b), 0);
    chk("rst_busy_a", 32'(busy_a), 0);       chk("rst_busy_b", 32'(busy_b), 0);
    chk("rst_done_a", 32'(done_a), 0);       chk("rst_done_b", 32'(done_b), 0);
    chk("rst_ovf_a", 32'(ovf_a), 0);         chk("rst_ovf_b", 32'(ovf_b), 0);
    load_a = 1'b0;
    load_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; load_a = 1'b0; load_b = 1'b0; bin_a = '0; bin_b = '0;
    for (int w = 0; w < 2; w++) begin
      next_ok[w] = 0; acc[w] = -100; disp_val[w] = 0; disp_ovf[w] = 0;
      prev_an[w] = 4'b1110; last_chg[w] = -1;
    end
    do_reset();
    repeat (6) @(negedge clk);

    // 10-bit instance: basic conversion and a full scan rotation
    do_load(0, 1023);
    repeat (24) @(negedge clk);
    // collision: a load during CONV is dropped
    do_load(0, 77);
    repeat (14) @(negedge clk);
    do_load(0, 1023);
    repeat (2) @(negedge clk);
    do_load(0, 5);
    repeat (14) @(negedge clk);
    do_load(0, 5);
    repeat (20) @(negedge clk);
    // load held every cycle: only every N+2 edges may be accepted
    for (int i = 0; i < 30; i++) do_load(0, $urandom_range(0, 1023));
    repeat (14) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 14)) @(negedge clk);
      do_load(0, $urandom_range(0, 1023));
    end
    repeat (16) @(negedge clk);

    // mid-scan reset
    do_reset();
    repeat (5) @(negedge clk);

    // 14-bit blanked instance: leading-zero blanking
    do_load(1, 7);
    repeat (24) @(negedge clk);
    do_load(1, 0);
    repeat (24) @(negedge clk);
    do_load(1, 1000);
    repeat (24) @(negedge clk);
    do_load(1, 1007);
    repeat (24) @(negedge clk);
    // overflow clamps to 9999
    do_load(1, 12345);
    repeat (24) @(negedge clk);
    // abort: reset during the fifth CONV cycle discards the result
    do_load(1, 42);
    repeat (3) @(posedge clk);
    do_reset();
    repeat (24) @(negedge clk);
    do_load(1, 42);
    repeat (24) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 18)) @(negedge clk);
      do_load(1, $urandom_range(0, 16383));
    end
    repeat (24) @(negedge clk);

    chk("pending_a", 32'(qa.size()), 0);
    chk("pending_b", 32'(qb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
